pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the five-stage core. It generates the enable and flush strobes for the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards, flushes on taken branches and freezes the pipeline during multi-cycle data-memory accesses. It sits beside the pipeline registers and drives their `en` inputs; a flush is implemented by the register loading a bubble (all control fields zero).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 10 +
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 73 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared pipeline encodings for the hazard controller
package pipe_hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;
  localparam logic [2:0] MEM_READ_NONE = 3'd0;
  localparam int REG_AW = 5;
endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load sitting in EX
import pipe_hazard_ctrl_pkg::*;

module load_use_detect (
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic [2:0]        ex_mem_read,
  output logic              hazard
);
  // x0 is never a real dependency, so a load targeting it cannot stall
  always_comb
    hazard = ex_mem_read != MEM_READ_NONE && ex_rd_addr != '0 &&
             ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
              (id_rs2_used && id_rs2_addr == ex_rd_addr));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline enable/flush generation for load-use, branch and memory-wait hazards
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_AW-1:0]    id_rs1_addr,
  input  logic [REG_AW-1:0]    id_rs2_addr,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_AW-1:0]    ex_rd_addr,
  input  logic [2:0]           ex_mem_read,
  input  logic                 ex_branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 if_id_flush,
  output logic                 id_ex_en,
  output logic                 id_ex_flush,
  output logic                 ex_mem_en,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic                 mem_timeout
);
  localparam int WW = MEM_TIMEOUT < 2 ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TMAX = WW'(MEM_TIMEOUT);
  state_t state, state_nxt;
  logic flush_pend, flush_pend_nxt, hazard, freeze, flush_all, lu;
  logic [WW-1:0] wait_cnt, wait_nxt;
  load_use_detect u_lud (
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd_addr  (ex_rd_addr),
    .ex_mem_read (ex_mem_read),
    .hazard      (hazard)
  );
  // Mealy decode: a memory wait freezes everything, a branch or pending flush beats load-use
  always_comb begin
    freeze = ((state == RUN && mem_req) || state == MEM_WAIT) && !mem_ready;
    flush_all = state == FLUSH || (!freeze && ex_branch_taken);
    lu = !freeze && !flush_all && hazard;
    pc_en = !rst && !freeze && !lu;
    if_id_en = !rst && !freeze && !lu;
    if_id_flush = !rst && flush_all;
    id_ex_en = !rst && !freeze;
    id_ex_flush = !rst && (flush_all || lu);
    ex_mem_en = !rst && !freeze;
    wait_nxt = !freeze ? '0 : wait_cnt == TMAX ? wait_cnt : wait_cnt + WW'(1);
    state_nxt = state == FLUSH ? RUN : freeze ? MEM_WAIT : (state == MEM_WAIT && flush_pend) ? FLUSH : RUN;
    flush_pend_nxt = state == FLUSH ? 1'b0 : flush_pend | (freeze && ex_branch_taken);
  end
  // State, pending-flush memory, wait/stall counters and the sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      flush_pend <= 1'b0;
      wait_cnt <= '0;
      stall_cycles <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      flush_pend <= flush_pend_nxt;
      wait_cnt <= wait_nxt;
      if (!pc_en) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      if (freeze && wait_nxt == TMAX) mem_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of load-use, branch, memory wait, timeout and reset behaviour
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
  logic id_rs1_used = 1'b0, id_rs2_used = 1'b0, ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic [2:0] ex_mem_read = '0;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_timeout;
  logic [31:0] stall_cycles;
  logic [5:0] o;
  int vec = 0, miss = 0;
  localparam logic [5:0] RUNP = 6'b110101, FLP = 6'b111111, LUP = 6'b000111, FRZ = 6'b000000;
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
  );
  assign o = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_outs", 32'(o), 32'(FRZ));
    chk("rst_stall", stall_cycles, 0);
    chk("rst_timeout", 32'(mem_timeout), 0);
    tick;
    rst = 1'b0;
    #1 chk("idle", 32'(o), 32'(RUNP));
    tick;
    ex_mem_read = 3'd2; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
    #1 chk("lu_rs1", 32'(o), 32'(LUP));
    tick;
    chk("lu_stall", stall_cycles, 1);
    ex_mem_read = 3'd0;
    #1 chk("lu_bubble", 32'(o), 32'(RUNP));
    ex_mem_read = 3'd2; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0;
    #1 chk("lu_rd0", 32'(o), 32'(RUNP));
    ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_rs1_used = 1'b0;
    #1 chk("lu_unused", 32'(o), 32'(RUNP));
    tick;
    chk("lu_nostall", stall_cycles, 1);
    id_rs2_addr = 5'd5; id_rs2_used = 1'b1;
    #1 chk("lu_rs2", 32'(o), 32'(LUP));
    tick;
    chk("lu_rs2_stall", stall_cycles, 2);
    ex_branch_taken = 1'b1;
    #1 chk("br_over_lu", 32'(o), 32'(FLP));
    tick;
    chk("br_stall", stall_cycles, 2);
    ex_branch_taken = 1'b0; ex_mem_read = 3'd0; id_rs2_used = 1'b0;
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("memwait_%0d", i), 32'(o), 32'(FRZ));
      tick;
    end
    mem_ready = 1'b1;
    #1 chk("mem_release", 32'(o), 32'(RUNP));
    tick;
    chk("mem_stall", stall_cycles, 5);
    #1 chk("mem_zero_wait", 32'(o), 32'(RUNP));
    tick;
    chk("mem_zero_stall", stall_cycles, 5);
    mem_ready = 1'b0;
    #1 chk("bw_enter", 32'(o), 32'(FRZ));
    tick;
    ex_branch_taken = 1'b1;
    #1 chk("bw_branch", 32'(o), 32'(FRZ));
    tick;
    ex_branch_taken = 1'b0; mem_ready = 1'b1;
    #1 chk("bw_release", 32'(o), 32'(RUNP));
    tick;
    mem_req = 1'b0; mem_ready = 1'b0;
    #1 chk("bw_flush", 32'(o), 32'(FLP));
    tick;
    chk("bw_run", 32'(o), 32'(RUNP));
    chk("bw_stall", stall_cycles, 7);
    mem_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("to_frz_%0d", i), 32'(o), 32'(FRZ));
      chk($sformatf("to_flag_%0d", i), 32'(mem_timeout), (i >= 4) ? 1 : 0);
      tick;
    end
    mem_ready = 1'b1;
    #1 chk("to_release", 32'(o), 32'(RUNP));
    tick;
    mem_req = 1'b0; mem_ready = 1'b0;
    chk("to_sticky", 32'(mem_timeout), 1);
    chk("to_stall", stall_cycles, 13);
    mem_req = 1'b1;
    tick;
    ex_branch_taken = 1'b1;
    tick;
    ex_branch_taken = 1'b0;
    rst = 1'b1;
    #1 chk("ar_outs", 32'(o), 32'(FRZ));
    chk("ar_stall", stall_cycles, 0);
    chk("ar_timeout", 32'(mem_timeout), 0);
    tick;
    rst = 1'b0; mem_req = 1'b0;
    #1 chk("ar_run", 32'(o), 32'(RUNP));
    tick;
    chk("ar_noflush", 32'(o), 32'(RUNP));
    chk("ar_stall_after", stall_cycles, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
